rgmii_rx: RTL
=============

Name: rgmii_rx

Overview:
- Receive-side Ethernet MAC for the RGMII PHY link.
- Consumes RX nibble pairs already demultiplexed by an external IDDR into the sysclk domain.
- Strips preamble/SFD, filters on destination address, extracts the header, streams the payload, and checks the FCS.
- Sits between the IDDR capture stage and the upper-layer (IP/ARP) parsers.

Parameters:
- MAC_ADDR, 48'h0, station address; frames addressed here or to FF:FF:FF:FF:FF:FF are accepted.
- PROMISC, 0, 1 = accept every destination address.
- MAX_FRAME, 16'd1518, maximum frame bytes (DA through FCS).
- MIN_FRAME, 16'd64, minimum frame bytes (DA through FCS).

Ports:
- clk  in  1  system clock; all inputs are sampled on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rx_d1  in  4  nibble from the rising PHY edge; low nibble of the byte.
- rx_d2  in  4  nibble from the falling PHY edge; high nibble of the byte.
- rx_ctl1  in  1  RX_CTL from the rising edge (RX_DV).
- rx_ctl2  in  1  RX_CTL from the falling edge (RX_DV xor RX_ER).
- mac_dest  out  48  received destination address; first wire byte lands in [47:40].
- mac_src  out  48  received source address; first wire byte lands in [47:40].
- ethertype  out  16  received type field; first wire byte lands in [15:8].
- hdr_valid  out  1  1-cycle pulse: mac_dest/mac_src/ethertype are valid and the frame was accepted.
- rx_data  out  8  payload byte.
- rx_valid  out  1  rx_data is valid this cycle.
- frame_done  out  1  1-cycle pulse at the end of an accepted frame.
- frame_ok  out  1  valid only with frame_done; 1 = good frame.

Behaviour:
- Byte/error decode, each cycle:
  - byte = {rx_d2, rx_d1}.
  - dv = rx_ctl1.
  - er = rx_ctl1 ^ rx_ctl2.
- Reset: state=IDLE and all counters cleared. Every output is 0, including the header registers.
- States: IDLE, PREAMBLE, DEST, SOURCE, TYPE, PAYLOAD, DROP.
- IDLE:
  - dv=1 and byte=8'h55 -> PREAMBLE.
  - dv=1 and byte=8'hD5 -> DEST.
  - dv=1 with any other byte -> DROP.
- PREAMBLE:
  - 8'h55 -> stay.
  - 8'hD5 -> DEST; CRC register is set to 32'hFFFFFFFF and the byte counter to 0.
  - Any other byte, or dv=0 -> DROP if dv=1, IDLE if dv=0.
  - There is no limit on preamble length.
- CRC: CRC-32, reflected polynomial 32'hEDB88320, byte-wide. It is updated on every byte from the first DA byte through the last FCS byte.
- DEST (6 bytes): bytes shift into mac_dest.
  - After byte 6, filter: accept = PROMISC | dest==MAC_ADDR | dest==all-ones.
  - Reject -> DROP, with no outputs for that frame.
- SOURCE (6 bytes) and TYPE (2 bytes): fill mac_src and ethertype.
- hdr_valid pulses on the cycle after the 14th byte is sampled.
- PAYLOAD, FCS holdback:
  - Bytes pass through a 4-byte delay line so the FCS is never emitted as payload.
  - When payload byte k+4 is sampled, byte k is presented on rx_data/rx_valid on the next cycle.
  - Padding is emitted as payload; upper layers trim it using their own length fields.
- End of frame (dv falls while in DEST..PAYLOAD):
  - frame_done pulses once on the next cycle, and the state returns to IDLE.
  - frame_ok=1 iff all of the following hold:
    - CRC register == 32'hDEBB20E3 (residue);
    - MIN_FRAME <= byte count <= MAX_FRAME;
    - er was never asserted during the frame;
    - dv fell in PAYLOAD.
  - If dv falls in DEST, the frame is silent and no frame_done is produced.
  - If dv falls in SOURCE or TYPE, frame_done pulses with frame_ok=0.
- Byte count is 16 bits and saturates at 16'hFFFF.
  - When count exceeds MAX_FRAME: stop rx_valid, latch the error, and go to DROP.
  - frame_done pulses with frame_ok=0 on the dv fall.
- er=1 in any state after DEST starts: latch the error and continue receiving. frame_ok is forced to 0.
- DROP: outputs stay idle until dv=0, then IDLE. frame_done is pulsed only if the frame was already accepted by the filter.
- Frame spacing: no IFG is required. dv=1 on the cycle after frame_done is a valid new frame start.
- Reset released while dv=1 -> DROP. The block never locks onto a frame mid-stream.
- The header registers hold their values until the next accepted frame overwrites them.

Test Plan:
- Minimum frame, 6B preamble+SFD, DA=MAC_ADDR, type 16'h0800, 46B payload 0x00..0x2D, correct FCS:
  - hdr_valid at byte 14;
  - exactly 46 rx_valid beats with values 0x00..0x2D;
  - frame_done=1 and frame_ok=1.
- Same frame with payload byte 10 flipped to 8'hFF: 46 beats, frame_ok=0.
- DA=02:00:00:00:00:99 (not local, PROMISC=0) -> no hdr_valid, rx_valid or frame_done. With DA=broadcast -> accepted, frame_ok=1.
- Runt frame, 40 bytes DA..FCS with a valid CRC -> frame_ok=0. Oversize frame, 1600 bytes -> rx_valid stops after 1514 bytes total, frame_ok=0.
- rx_ctl2 toggled so er=1 for one cycle in payload -> frame_ok=0 and all payload still streamed. Next frame starting 1 cycle after frame_done -> frame_ok=1.
- rst pulsed low mid-payload -> all outputs 0 immediately. Reset released while dv=1 -> no output until dv low; the following good frame passes.

Source files
------------

// File: rtl/rgmii_rx.sv
// RGMII receive MAC: preamble/SFD strip, DA filter, header extraction,
// payload streaming with 4-byte FCS holdback, and CRC-32/length/error checking.
module rgmii_rx #(
    parameter logic [47:0] MAC_ADDR  = 48'h0,
    parameter bit          PROMISC   = 1'b0,
    parameter logic [15:0] MAX_FRAME = 16'd1518,
    parameter logic [15:0] MIN_FRAME = 16'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rx_d1,
    input  logic [3:0]  rx_d2,
    input  logic        rx_ctl1,
    input  logic        rx_ctl2,
    output logic [47:0] mac_dest,
    output logic [47:0] mac_src,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_done,
    output logic        frame_ok
);

    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        StIdle, StPreamble, StDest, StSource, StType, StPayload, StDrop
    } state_e;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              acc_q, acc_d;
    logic              seen_low_q, seen_low_d;
    logic [39:0]       dest_sr_q, dest_sr_d;
    logic [3:0][7:0]   dl_q, dl_d;
    logic [2:0]        fill_q, fill_d;
    logic [47:0]       mac_dest_q, mac_dest_d;
    logic [47:0]       mac_src_q, mac_src_d;
    logic [15:0]       etype_q, etype_d;
    logic              hdr_valid_q, hdr_valid_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;

    logic [7:0]  byte_in;
    logic        dv, er;
    logic [31:0] crc_next;
    logic [15:0] cnt_inc;
    logic [47:0] dest_full;
    logic        frame_good;

    assign byte_in   = {rx_d2, rx_d1};
    assign dv        = rx_ctl1;
    assign er        = rx_ctl1 ^ rx_ctl2;
    assign crc_next  = crc_byte(crc_q, byte_in);
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign dest_full = {dest_sr_q, byte_in};
    assign frame_good = (crc_q == CrcResidue) && (cnt_q >= MIN_FRAME) &&
                        (cnt_q <= MAX_FRAME) && !err_q;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        acc_d       = acc_q;
        seen_low_d  = seen_low_q | ~dv;
        dest_sr_d   = dest_sr_q;
        dl_d        = dl_q;
        fill_d      = fill_q;
        mac_dest_d  = mac_dest_q;
        mac_src_d   = mac_src_q;
        etype_d     = etype_q;
        hdr_valid_d = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        done_d      = 1'b0;
        ok_d        = 1'b0;

        case (state_q)
            StIdle, StPreamble: begin
                if (!dv) begin
                    state_d = StIdle;
                end else if (state_q == StIdle && !seen_low_q) begin
                    // dv already high when reset released: never join mid-stream
                    state_d = StDrop;
                end else if (byte_in == 8'h55) begin
                    state_d = StPreamble;
                end else if (byte_in == 8'hD5) begin
                    state_d = StDest;
                    crc_d   = 32'hFFFFFFFF;
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
                    acc_d   = 1'b0;
                end else begin
                    state_d = StDrop;
                end
            end
            StDest, StSource, StType, StPayload: begin
                if (!dv) begin
                    state_d = StIdle;
                    if (state_q != StDest) begin
                        done_d = 1'b1;
                        ok_d   = frame_good && (state_q == StPayload);
                    end
                end else begin
                    crc_d = crc_next;
                    cnt_d = cnt_inc;
                    if (er) err_d = 1'b1;
                    if (state_q == StDest) begin
                        dest_sr_d = dest_full[39:0];
                        if (cnt_q == 16'd5) begin
                            if (PROMISC || dest_full == MAC_ADDR || dest_full == '1) begin
                                state_d    = StSource;
                                acc_d      = 1'b1;
                                mac_dest_d = dest_full;
                            end else begin
                                state_d = StDrop;
                            end
                        end
                    end else if (state_q == StSource) begin
                        mac_src_d = {mac_src_q[39:0], byte_in};
                        if (cnt_q == 16'd11) state_d = StType;
                    end else if (state_q == StType) begin
                        etype_d = {etype_q[7:0], byte_in};
                        if (cnt_q == 16'd13) begin
                            state_d     = StPayload;
                            hdr_valid_d = 1'b1;
                            fill_d      = 3'd0;
                        end
                    end else if (cnt_inc > MAX_FRAME) begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end else begin
                        // Last four bytes stay in the delay line, so the FCS never leaks out
                        dl_d = {dl_q[2:0], byte_in};
                        if (fill_q == 3'd4) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = dl_q[3];
                        end else begin
                            fill_d = fill_q + 3'd1;
                        end
                    end
                end
            end
            StDrop: begin
                if (!dv) begin
                    state_d = StIdle;
                    done_d  = acc_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            crc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            acc_q       <= 1'b0;
            seen_low_q  <= 1'b0;
            dest_sr_q   <= '0;
            dl_q        <= '0;
            fill_q      <= '0;
            mac_dest_q  <= '0;
            mac_src_q   <= '0;
            etype_q     <= '0;
            hdr_valid_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            seen_low_q  <= seen_low_d;
            dest_sr_q   <= dest_sr_d;
            dl_q        <= dl_d;
            fill_q      <= fill_d;
            mac_dest_q  <= mac_dest_d;
            mac_src_q   <= mac_src_d;
            etype_q     <= etype_d;
            hdr_valid_q <= hdr_valid_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
        end
    end

    assign mac_dest   = mac_dest_q;
    assign mac_src    = mac_src_q;
    assign ethertype  = etype_q;
    assign hdr_valid  = hdr_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;

endmodule
